// File: rtl/mux_display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display receiver.
package mux_display_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned VALUE_W  = 10;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned SEL_W    = 4;

  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;

  localparam logic [7:0] DP_MASK = 8'h7F;

  localparam logic [SEL_W-1:0] SEL_UNI = 4'b1110;
  localparam logic [SEL_W-1:0] SEL_DEC = 4'b1101;
  localparam logic [SEL_W-1:0] SEL_CEN = 4'b1011;
  localparam logic [SEL_W-1:0] SEL_OFF = 4'b1111;

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_EMIT} state_t;

  // One registered bus sample: select lines plus segments with dp stripped.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SEG_W-1:0] seg;
  } sample_t;

endpackage

// File: rtl/mux_display_decoder_seg7.sv
// Active-low 7-segment code to decimal nibble; anything else is not decimal.
module seg7_decoder
  import mux_display_pkg::*;
(
  input  logic [SEG_W-1:0]    code,
  output logic [NIBBLE_W-1:0] nibble,
  output logic                is_decimal
);

  localparam logic [SEG_W-1:0] C0 = SEG_0[6:0];
  localparam logic [SEG_W-1:0] C1 = SEG_1[6:0];
  localparam logic [SEG_W-1:0] C2 = SEG_2[6:0];
  localparam logic [SEG_W-1:0] C3 = SEG_3[6:0];
  localparam logic [SEG_W-1:0] C4 = SEG_4[6:0];
  localparam logic [SEG_W-1:0] C5 = SEG_5[6:0];
  localparam logic [SEG_W-1:0] C6 = SEG_6[6:0];
  localparam logic [SEG_W-1:0] C7 = SEG_7[6:0];
  localparam logic [SEG_W-1:0] C8 = SEG_8[6:0];
  localparam logic [SEG_W-1:0] C9 = SEG_9[6:0];

  always_comb begin
    nibble     = '0;
    is_decimal = 1'b1;
    case (code)
      C0:      nibble = 4'd0;
      C1:      nibble = 4'd1;
      C2:      nibble = 4'd2;
      C3:      nibble = 4'd3;
      C4:      nibble = 4'd4;
      C5:      nibble = 4'd5;
      C6:      nibble = 4'd6;
      C7:      nibble = 4'd7;
      C8:      nibble = 4'd8;
      C9:      nibble = 4'd9;
      default: is_decimal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mux_display_decoder.sv
// Reconstructs the three scanned digits of a multiplexed 7-segment bus into a binary value.
module mux_display_decoder
  import mux_display_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            segmentos,
  input  logic [SEL_W-1:0]      sel_seg,
  output logic [VALUE_W-1:0]    value_out,
  output logic [3*NIBBLE_W-1:0] digits_out,
  output logic                  value_valid,
  output logic                  value_changed,
  output logic                  code_err,
  output logic                  sel_err,
  output logic                  stale
);

  localparam int unsigned STAB_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam sample_t BLANK_SAMPLE = '{sel: SEL_OFF, seg: 7'h7F};

  sample_t                    smp_q;
  sample_t                    smp_p;
  logic [STAB_W-1:0]          stab_cnt;
  logic [TMO_W-1:0]           tmo_cnt;
  state_t                     state;
  logic [2:0]                 got;
  logic [2:0][NIBBLE_W-1:0]   nib;
  logic                       have_prev;

  logic                       same_c;
  logic                       stable_c;
  logic                       dig_sel_c;
  logic                       blank_c;
  logic [1:0]                 slot_c;
  logic [2:0]                 got_set_c;
  logic [NIBBLE_W-1:0]        nibble_c;
  logic                       is_dec_c;
  logic [VALUE_W-1:0]         value_c;

  seg7_decoder u_dec (
    .code       (smp_q.seg),
    .nibble     (nibble_c),
    .is_decimal (is_dec_c)
  );

  // Input register, one-sample history and run-length of identical samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_q    <= BLANK_SAMPLE;
      smp_p    <= BLANK_SAMPLE;
      stab_cnt <= '0;
    end else begin
      smp_q    <= '{sel: sel_seg, seg: SEG_W'(segmentos & DP_MASK)};
      smp_p    <= smp_q;
      if (!same_c)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + STAB_W'(1);
    end
  end

  assign same_c   = (smp_q == smp_p);
  assign stable_c = (stab_cnt == STAB_MAX);

  always_comb begin
    dig_sel_c = 1'b1;
    blank_c   = 1'b0;
    slot_c    = 2'd0;
    case (smp_q.sel)
      SEL_UNI: slot_c = 2'd0;
      SEL_DEC: slot_c = 2'd1;
      SEL_CEN: slot_c = 2'd2;
      SEL_OFF: begin
        dig_sel_c = 1'b0;
        blank_c   = 1'b1;
      end
      default: dig_sel_c = 1'b0;
    endcase
  end

  assign got_set_c = got | (3'b001 << slot_c);
  assign value_c   = VALUE_W'(nib[2]) * 10'd100 + VALUE_W'(nib[1]) * 10'd10 + VALUE_W'(nib[0]);

  // Capture FSM; S_HOLD leaves once the dwell that was accepted stops being stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_WAIT;
      got           <= '0;
      nib           <= '0;
      have_prev     <= 1'b0;
      value_out     <= '0;
      digits_out    <= '0;
      value_valid   <= 1'b0;
      value_changed <= 1'b0;
      code_err      <= 1'b0;
      sel_err       <= 1'b0;
    end else begin
      value_valid   <= 1'b0;
      value_changed <= 1'b0;
      case (state)
        S_WAIT: begin
          if (stable_c) begin
            if (dig_sel_c) begin
              if (is_dec_c) begin
                nib[slot_c] <= nibble_c;
                got         <= got_set_c;
                state       <= (got_set_c == 3'b111) ? S_EMIT : S_HOLD;
              end else begin
                code_err <= 1'b1;
                state    <= S_HOLD;
              end
            end else if (!blank_c) begin
              sel_err <= 1'b1;
              state   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stable_c)
            state <= S_WAIT;
        end
        S_EMIT: begin
          value_out     <= value_c;
          digits_out    <= nib;
          value_valid   <= 1'b1;
          value_changed <= !have_prev || (value_c != value_out);
          have_prev     <= 1'b1;
          got           <= '0;
          state         <= S_HOLD;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // Frame watchdog; an emit restart wins over saturation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      stale   <= 1'b0;
    end else if (state == S_EMIT) begin
      tmo_cnt <= '0;
      stale   <= 1'b0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
      stale   <= ((tmo_cnt + TMO_W'(1)) == TMO_MAX);
    end else begin
      stale   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_display_decoder.sv
// Scoreboard bench for mux_display_decoder: expected frames queued at scan time, checked on value_valid.
module tb_mux_display_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  segmentos = 8'hFF;
  logic [3:0]  sel_seg = 4'hF;
  logic [9:0]  value_out;
  logic [11:0] digits_out;
  logic        value_valid;
  logic        value_changed;
  logic        code_err;
  logic        sel_err;
  logic        stale;

  mux_display_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk           (clk),
    .rst           (rst),
    .segmentos     (segmentos),
    .sel_seg       (sel_seg),
    .value_out     (value_out),
    .digits_out    (digits_out),
    .value_valid   (value_valid),
    .value_changed (value_changed),
    .code_err      (code_err),
    .sel_err       (sel_err),
    .stale         (stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0]  v;
    logic [11:0] d;
    logic        ch;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_vcyc = 0;
  logic [9:0] prev_v = '0;
  bit         have_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  task automatic push_exp(input int h, input int t, input int u);
    exp_t e;
    e.v  = 10'(h * 100 + t * 10 + u);
    e.d  = 12'(h * 256 + t * 16 + u);
    e.ch = !have_prev || (e.v != prev_v);
    prev_v    = e.v;
    have_prev = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [7:0] seg, input logic [3:0] sel, input int n);
    @(negedge clk);
    segmentos = seg;
    sel_seg   = sel;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan(input int h, input int t, input int u, input bit glitch);
    push_exp(h, t, u);
    hold(seg_of(u), 4'b1110, 12);
    if (glitch) hold(8'h00, 4'b1100, 2);
    hold(seg_of(t), 4'b1101, 12);
    if (glitch) hold(8'h00, 4'b1100, 2);
    hold(seg_of(h), 4'b1011, 12);
  endtask

  // Output monitor: every value_valid must match the oldest queued frame.
  always @(negedge clk) begin : mon
    exp_t e;
    if (value_valid) begin
      last_vcyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("value_out", 32'(value_out), 32'(e.v));
        check("digits_out", 32'(digits_out), 32'(e.d));
        check("value_changed", 32'(value_changed), 32'(e.ch));
        check("stale_on_valid", 32'(stale), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, 32'(value_out), 32'd0);
    check({tag, "_digits"}, 32'(digits_out), 32'd0);
    check({tag, "_valid"}, 32'(value_valid), 32'd0);
    check({tag, "_changed"}, 32'(value_changed), 32'd0);
    check({tag, "_code_err"}, 32'(code_err), 32'd0);
    check({tag, "_sel_err"}, 32'(sel_err), 32'd0);
    check({tag, "_stale"}, 32'(stale), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    hold(8'hFF, 4'b1111, 4);

    // Plain scans, repeat of the same value, then a new value.
    scan(1, 3, 7, 1'b0);
    scan(1, 3, 7, 1'b0);
    scan(2, 5, 5, 1'b0);

    // Short transition glitches between digits must be ignored.
    scan(3, 8, 4, 1'b1);
    check("sel_err_after_glitch", 32'(sel_err), 32'd0);
    check("code_err_after_glitch", 32'(code_err), 32'd0);

    // Hex units code: flagged, frame held back until a decimal units digit.
    hold(8'h88, 4'b1110, 12);
    check("code_err_set", 32'(code_err), 32'd1);
    hold(seg_of(1), 4'b1101, 12);
    hold(seg_of(2), 4'b1011, 12);
    push_exp(2, 1, 5);
    hold(seg_of(5), 4'b1110, 12);
    check("sel_err_pre", 32'(sel_err), 32'd0);
    hold(seg_of(3), 4'b1001, 12);
    check("sel_err_set", 32'(sel_err), 32'd1);
    hold(8'hFF, 4'b1111, 2);
    check("code_err_sticky", 32'(code_err), 32'd1);

    // Stop scanning: stale exactly TIMEOUT_CYCLES after the last emit.
    for (int i = 0; i < 200 && cyc < last_vcyc + 49; i++) @(negedge clk);
    check("tmo_window", 32'(cyc), 32'(last_vcyc + 49));
    check("stale_before", 32'(stale), 32'd0);
    @(negedge clk);
    check("stale_at_timeout", 32'(stale), 32'd1);
    repeat (10) @(negedge clk);
    check("stale_held", 32'(stale), 32'd1);
    scan(0, 4, 2, 1'b0);
    hold(8'hFF, 4'b1111, 4);
    check("stale_cleared", 32'(stale), 32'd0);

    // Reset mid-frame discards the captured units and tens.
    hold(seg_of(0), 4'b1110, 12);
    hold(seg_of(0), 4'b1101, 12);
    @(negedge clk);
    rst       = 1'b1;
    segmentos = 8'hFF;
    sel_seg   = 4'b1111;
    #2;
    check_all_zero("midrst");
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold(8'hFF, 4'b1111, 4);
    scan(9, 0, 0, 1'b0);
    hold(8'hFF, 4'b1111, 10);
    check("final_value", 32'(value_out), 32'd900);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("sel_err_after_rst", 32'(sel_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
